cpmg_seq: RTL and testbench

//  Parametrised CPMG pulse-train sequencer; successor to the fixed single-train generator.

---
 rtl/cpmg_seq.sv | 191 +++++++++++++++++++
 tb/tb_cpmg_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpmg_seq.sv
// cpmg_seq: CPMG pulse-train sequencer producing DDS amplitude words with start/busy/done handshake.
// Optional feature macro CPMG_PHASE_ALT_EN alternates the sign of successive 180 pulses.
module cpmg_seq #(
  parameter int DW = 16,
  parameter int CW = 32,
  parameter int NW = 16,
  parameter int S  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   delay_cyc,
  input  logic [CW-1:0] t90,
  input  logic [CW-1:0] tau_l,
  input  logic [NW-1:0] n_echo,
  input  logic [DW-1:0] amp_90,
  input  logic [DW-1:0] amp_180,
  output logic [DW-1:0] data,
  output logic          acq_gate,
  output logic          phase,
  output logic [NW-1:0] echo_idx,
  output logic          busy,
  output logic          done
);
  localparam int TW = CW + 3;

  typedef enum logic [2:0] {IDLE, DELAY, P90, GAP1, P180, GAP2} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          acq_q, acq_d;
  logic          phase_q, phase_d;
  logic [NW-1:0] echo_q, echo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [TW-1:0]        w90_q, g1_q;
  logic [NW-1:0]        n_q;
  logic [DW-1:0]        a90_q;
  logic signed [DW-1:0] a180_q;
  logic                 load_cfg;

  logic [TW-1:0]        w90_in, g1_in, delay_in;
  logic                 ph_next;
  logic signed [DW-1:0] p180_data;
  logic                 enter_p180, finish;

  assign w90_in   = {{(TW-CW){1'b0}}, t90} << S;
  assign g1_in    = {{(TW-CW){1'b0}}, tau_l} << S;
  assign delay_in = {{(TW-16){1'b0}}, delay_cyc};

`ifdef CPMG_PHASE_ALT_EN
  assign ph_next   = ~phase_q;
  assign p180_data = ph_next ? a180_q : -a180_q;
`else
  assign ph_next   = 1'b0;
  assign p180_data = a180_q;
`endif

  // Counter preload: an interval of length L occupies L cycles, never fewer than one.
  function automatic logic [TW-1:0] len_m1(input logic [TW-1:0] len);
    return (len == '0) ? '0 : len - TW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    acq_d      = acq_q;
    phase_d    = phase_q;
    echo_d     = echo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_cfg   = 1'b0;
    enter_p180 = 1'b0;
    finish     = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      data_d  = '0;
      acq_d   = 1'b0;
      phase_d = 1'b0;
      busy_d  = 1'b0;
    end else if (state_q != IDLE && cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          // done_q blocks a start that coincides with the completion pulse.
          if (start && !abort && !done_q) begin
            load_cfg = 1'b1;
            busy_d   = 1'b1;
            echo_d   = '0;
            phase_d  = 1'b0;
            if (delay_cyc == '0) begin
              state_d = P90;
              cnt_d   = len_m1(w90_in);
              data_d  = amp_90;
            end else begin
              state_d = DELAY;
              cnt_d   = delay_in - TW'(1);
            end
          end
        end
        DELAY: begin
          state_d = P90;
          cnt_d   = len_m1(w90_q);
          data_d  = a90_q;
        end
        P90: begin
          state_d = GAP1;
          cnt_d   = len_m1(g1_q);
          data_d  = '0;
        end
        GAP1: begin
          if (n_q == '0) finish = 1'b1;
          else           enter_p180 = 1'b1;
        end
        P180: begin
          state_d = GAP2;
          cnt_d   = len_m1(g1_q << 1);
          data_d  = '0;
          acq_d   = 1'b1;
        end
        GAP2: begin
          acq_d = 1'b0;
          if (echo_q < n_q) enter_p180 = 1'b1;
          else              finish = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (enter_p180) begin
        state_d = P180;
        cnt_d   = len_m1(w90_q << 1);
        data_d  = p180_data;
        phase_d = ph_next;
        echo_d  = echo_q + NW'(1);
      end
      if (finish) begin
        state_d = IDLE;
        data_d  = '0;
        acq_d   = 1'b0;
        phase_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      acq_q   <= 1'b0;
      phase_q <= 1'b0;
      echo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      acq_q   <= acq_d;
      phase_q <= phase_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Configuration snapshot taken on the accepting edge; ignored while busy.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      w90_q  <= w90_in;
      g1_q   <= g1_in;
      n_q    <= n_echo;
      a90_q  <= amp_90;
      a180_q <= amp_180;
    end
  end

  assign data     = data_q;
  assign acq_gate = acq_q;
  assign phase    = phase_q;
  assign echo_idx = echo_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cpmg_seq.sv
// Directed scoreboard bench for cpmg_seq: expected per-cycle outputs are queued at start and popped each cycle.
module tb_cpmg_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] delay_cyc;
  logic [31:0] t90;
  logic [31:0] tau_l;
  logic [15:0] n_echo;
  logic [15:0] amp_90;
  logic [15:0] amp_180;
  logic [15:0] data;
  logic        acq_gate;
  logic        phase;
  logic [15:0] echo_idx;
  logic        busy;
  logic        done;

  cpmg_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_cyc(delay_cyc), .t90(t90), .tau_l(tau_l), .n_echo(n_echo),
    .amp_90(amp_90), .amp_180(amp_180),
    .data(data), .acq_gate(acq_gate), .phase(phase), .echo_idx(echo_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        acq;
    logic        busy;
    logic        done;
    logic        phase;
    logic [15:0] echo;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  function automatic exp_t mk(input logic [15:0] d, input logic a, input logic b,
                              input logic dn, input logic ph, input logic [15:0] e);
    exp_t r;
    r.data = d; r.acq = a; r.busy = b; r.done = dn; r.phase = ph; r.echo = e;
    return r;
  endfunction

  function automatic exp_t observed();
    return mk(data, acq_gate, busy, done, phase, echo_idx);
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed data=%h acq=%b busy=%b done=%b phase=%b echo=%0d expected data=%h acq=%b busy=%b done=%b phase=%b echo=%0d",
             tag, obs.data, obs.acq, obs.busy, obs.done, obs.phase, obs.echo,
             want.data, want.acq, want.busy, want.done, want.phase, want.echo);
    end
  endtask

  function automatic int atleast1(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // Expand one complete sequence into per-cycle expectations, ending with the done and one idle cycle.
  task automatic push_train(input int dly, input int tw, input int tg, input int n,
                            input logic [15:0] a90, input logic [15:0] a180);
    int          w90, g1, w180, g2;
    logic        ph;
    logic [15:0] word;
    w90  = atleast1(tw * 4);
    g1   = atleast1(tg * 4);
    w180 = atleast1(tw * 8);
    g2   = atleast1(tg * 8);
    for (int i = 0; i < dly; i++) sb.push_back(mk(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < w90; i++) sb.push_back(mk(a90, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < g1; i++)  sb.push_back(mk(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    for (int e = 1; e <= n; e++) begin
`ifdef CPMG_PHASE_ALT_EN
      ph   = (e % 2) == 1;
      word = ph ? a180 : (~a180 + 16'd1);
`else
      ph   = 1'b0;
      word = a180;
`endif
      for (int i = 0; i < w180; i++) sb.push_back(mk(word, 1'b0, 1'b1, 1'b0, ph, 16'(e)));
      for (int i = 0; i < g2; i++)   sb.push_back(mk(16'h0, 1'b1, 1'b1, 1'b0, ph, 16'(e)));
    end
    sb.push_back(mk(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'(n)));
    sb.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(n)));
  endtask

  task automatic kick(input int dly, input int tw, input int tg, input int n,
                      input logic [15:0] a90, input logic [15:0] a180);
    delay_cyc = 16'(dly);
    t90       = 32'(tw);
    tau_l     = 32'(tg);
    n_echo    = 16'(n);
    amp_90    = a90;
    amp_180   = a180;
    start     = 1'b1;
    push_train(dly, tw, tg, n, a90, a180);
  endtask

  // poke: mid-run start plus config scramble, and a start coinciding with done.
  task automatic drain(input string tag, input int n, input bit poke);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty at step %0d", tag, i);
        break;
      end
      e = sb.pop_front();
      check(tag, observed(), e);
      if (poke && i == 40) begin
        start = 1'b1; t90 = 32'd7; tau_l = 32'd1; n_echo = 16'd9;
        amp_90 = 16'h1111; amp_180 = 16'h2222; delay_cyc = 16'd0;
      end
      if (poke && i == 41) start = 1'b0;
      if (poke && i == n - 2) start = 1'b1;
      if (poke && i == n - 1) start = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b1;
    abort     = 1'b0;
    delay_cyc = 16'hFFFF;
    t90       = $urandom;
    tau_l     = $urandom;
    n_echo    = 16'($urandom);
    amp_90    = 16'($urandom);
    amp_180   = 16'($urandom);
    repeat (2) begin
      @(negedge clk);
      check("reset", observed(), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", observed(), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    end

    kick(3, 2, 5, 2, 16'h43CA, 16'h7FFF);
    drain("cpmg_n2", sb.size(), 1'b1);

    kick(3, 2, 5, 0, 16'h43CA, 16'h7FFF);
    drain("cpmg_n0", sb.size(), 1'b0);

    kick(3, 2, 5, 2, 16'h43CA, 16'h7FFF);
    drain("pre_abort", 35, 1'b0);
    abort = 1'b1;
    sb.delete();
    sb.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
    drain("abort_p180", 1, 1'b0);
    abort = 1'b0;
    kick(3, 2, 5, 2, 16'h43CA, 16'h7FFF);
    drain("rerun_after_abort", sb.size(), 1'b0);

    abort = 1'b1;
    start = 1'b1;
    sb.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    drain("abort_start_idle", 1, 1'b0);
    abort = 1'b0;
    sb.push_back(mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    drain("abort_start_hold", 1, 1'b0);

    kick(3, 2, 5, 2, 16'h43CA, 16'h7FFF);
    drain("pre_rst", 60, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst_gap2", observed(), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst_held", observed(), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    @(negedge clk);
    check("idle_after_rst", observed(), mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));

    kick(0, 0, 1, 3, 16'h0F0F, 16'h1234);
    drain("zero_len", sb.size(), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
